// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// State encodings, default parameter values and the load-use hazard predicate.
package pipe_ctrl_pkg;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_WAIT = 1'b1
    } pc_state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int WAIT_CNT_W      = 8;

    // A load in EXE blocks the ID instruction only if it writes a real register that ID reads.
    function automatic logic load_use_hit(
        input logic       mem_r_en,
        input logic [4:0] dest,
        input logic [4:0] src1,
        input logic [4:0] src2,
        input logic       uses_src2
    );
        return mem_r_en && (dest != 5'd0) &&
               ((dest == src1) || (uses_src2 && (dest == src2)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter used for the hazard performance statistics.
// Holds at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes and data-memory wait sequencing with timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src2,
    input  logic [4:0]       exe_dest,
    input  logic             exe_mem_r_en,
    input  logic             exe_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if2id_freeze,
    output logic             if2id_flush,
    output logic             id2exe_freeze,
    output logic             id2exe_bubble,
    output logic             exe2mem_freeze,
    output logic             mem2wb_bubble,
    output logic             busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stalls,
    output logic [CNT_W-1:0] br_flushes,
    output logic [CNT_W-1:0] mem_waits
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    pc_state_e             state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  timeout;
    logic                  mem_stall;
    logic                  load_use;
    logic                  br_flush;
    logic                  lu_bubble;

    assign timeout  = (state == PC_WAIT) && (wait_cnt == TIMEOUT_VAL);
    assign load_use = load_use_hit(exe_mem_r_en, exe_dest, id_src1, id_src2, id_uses_src2);

    // Once in WAIT the request is already latched downstream, so only readiness and timeout matter.
    assign mem_stall = (state == PC_RUN) ? (mem_req && !mem_ready)
                                         : (!mem_ready && !timeout);

    // A taken branch squashes the ID instruction, so its load-use hazard is moot.
    assign br_flush  = !mem_stall && exe_br_taken;
    assign lu_bubble = !mem_stall && !exe_br_taken && load_use;

    assign busy = (state == PC_WAIT);

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        pc_freeze      = 1'b0;
        if2id_freeze   = 1'b0;
        if2id_flush    = 1'b0;
        id2exe_freeze  = 1'b0;
        id2exe_bubble  = 1'b0;
        exe2mem_freeze = 1'b0;
        mem2wb_bubble  = 1'b0;
        if (mem_stall) begin
            pc_freeze      = 1'b1;
            if2id_freeze   = 1'b1;
            id2exe_freeze  = 1'b1;
            exe2mem_freeze = 1'b1;
            mem2wb_bubble  = 1'b1;
        end else if (br_flush) begin
            if2id_flush   = 1'b1;
            id2exe_bubble = 1'b1;
        end else if (lu_bubble) begin
            pc_freeze     = 1'b1;
            if2id_freeze  = 1'b1;
            id2exe_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PC_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                PC_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= PC_WAIT;
                        wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                PC_WAIT: begin
                    if (mem_ready) begin
                        state    <= PC_RUN;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        // The access is abandoned; the error stays up until reset.
                        mem_err  <= 1'b1;
                        state    <= PC_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    state    <= PC_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (lu_bubble),
        .count (lu_stalls)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_flush),
        .count (br_flushes)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_stall),
        .count (mem_waits)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a default instance and a small one (timeout 4, 2-bit counters)
// share the stimulus; a per-cycle reference model feeds a scoreboard checked at negedge.
module tb_pipe_ctrl;

    typedef struct {
        logic [4:0] src1;
        logic [4:0] src2;
        logic       uses2;
        logic [4:0] dest;
        logic       mr_en;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic [6:0] ctl;
        logic       busy;
        logic       err;
        int         lu;
        int         br;
        int         mw;
    } exp_t;

    typedef struct {
        bit waiting;
        int stalled;
        bit err;
        int lu;
        int br;
        int mw;
    } model_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_src1, id_src2, exe_dest;
    logic       id_uses_src2, exe_mem_r_en, exe_br_taken, mem_req, mem_ready;

    logic        b_pc_freeze, b_if2id_freeze, b_if2id_flush, b_id2exe_freeze;
    logic        b_id2exe_bubble, b_exe2mem_freeze, b_mem2wb_bubble, b_busy, b_mem_err;
    logic [15:0] b_lu, b_br, b_mw;
    logic        s_pc_freeze, s_if2id_freeze, s_if2id_flush, s_id2exe_freeze;
    logic        s_id2exe_bubble, s_exe2mem_freeze, s_mem2wb_bubble, s_busy, s_mem_err;
    logic [1:0]  s_lu, s_br, s_mw;

    int errors = 0;
    int checks = 0;

    exp_t   q_big[$];
    exp_t   q_small[$];
    model_t m[2];
    int     tmo[2]  = '{255, 4};
    int     cmax[2] = '{65535, 3};

    pipe_ctrl u_big (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .exe_br_taken(exe_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(b_pc_freeze), .if2id_freeze(b_if2id_freeze), .if2id_flush(b_if2id_flush),
        .id2exe_freeze(b_id2exe_freeze), .id2exe_bubble(b_id2exe_bubble),
        .exe2mem_freeze(b_exe2mem_freeze), .mem2wb_bubble(b_mem2wb_bubble),
        .busy(b_busy), .mem_err(b_mem_err),
        .lu_stalls(b_lu), .br_flushes(b_br), .mem_waits(b_mw)
    );

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .exe_br_taken(exe_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(s_pc_freeze), .if2id_freeze(s_if2id_freeze), .if2id_flush(s_if2id_flush),
        .id2exe_freeze(s_id2exe_freeze), .id2exe_bubble(s_id2exe_bubble),
        .exe2mem_freeze(s_exe2mem_freeze), .mem2wb_bubble(s_mem2wb_bubble),
        .busy(s_busy), .mem_err(s_mem_err),
        .lu_stalls(s_lu), .br_flushes(s_br), .mem_waits(s_mw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.src1 = 5'd0; s.src2 = 5'd0; s.uses2 = 1'b0; s.dest = 5'd0;
        s.mr_en = 1'b0; s.br = 1'b0; s.req = 1'b0; s.rdy = 1'b0;
        return s;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // One clock cycle: drive inputs, push each instance's expected response, advance the model.
    task automatic step(input logic r, input stim_t s);
        bit   lu_hit, stall;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        id_src1 = s.src1; id_src2 = s.src2; id_uses_src2 = s.uses2; exe_dest = s.dest;
        exe_mem_r_en = s.mr_en; exe_br_taken = s.br; mem_req = s.req; mem_ready = s.rdy;
        lu_hit = s.mr_en && (s.dest != 0) &&
                 ((s.dest == s.src1) || (s.uses2 && (s.dest == s.src2)));
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m[k].waiting = 0; m[k].stalled = 0; m[k].err = 0;
                m[k].lu = 0; m[k].br = 0; m[k].mw = 0;
            end
            // An access stalls until ready, but never for more than the timeout's worth of cycles.
            if (m[k].waiting) stall = !s.rdy && (m[k].stalled < tmo[k]);
            else              stall = s.req && !s.rdy;
            if (stall)        e.ctl = 7'b1101011;
            else if (s.br)    e.ctl = 7'b0010100;
            else if (lu_hit)  e.ctl = 7'b1100100;
            else              e.ctl = 7'b0000000;
            e.busy = m[k].waiting;
            e.err  = m[k].err;
            e.lu   = m[k].lu;
            e.br   = m[k].br;
            e.mw   = m[k].mw;
            if (k == 0) q_big.push_back(e);
            else        q_small.push_back(e);
            if (r) begin
                if (stall)                      m[k].mw = sat_inc(m[k].mw, cmax[k]);
                else if (s.br)                  m[k].br = sat_inc(m[k].br, cmax[k]);
                else if (lu_hit)                m[k].lu = sat_inc(m[k].lu, cmax[k]);
                if (stall) begin
                    m[k].waiting = 1;
                    m[k].stalled++;
                end else begin
                    if (m[k].waiting && !s.rdy) m[k].err = 1;
                    m[k].waiting = 0;
                    m[k].stalled = 0;
                end
            end
        end
    endtask

    // Monitor: every cycle's outputs are compared against the scoreboard head at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_big.size() > 0) begin
                e = q_big.pop_front();
                check("big.ctl", 32'({b_pc_freeze, b_if2id_freeze, b_if2id_flush, b_id2exe_freeze,
                                      b_id2exe_bubble, b_exe2mem_freeze, b_mem2wb_bubble}), 32'(e.ctl));
                check("big.busy", 32'(b_busy), 32'(e.busy));
                check("big.mem_err", 32'(b_mem_err), 32'(e.err));
                check("big.lu_stalls", 32'(b_lu), e.lu);
                check("big.br_flushes", 32'(b_br), e.br);
                check("big.mem_waits", 32'(b_mw), e.mw);
            end
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                check("small.ctl", 32'({s_pc_freeze, s_if2id_freeze, s_if2id_flush, s_id2exe_freeze,
                                        s_id2exe_bubble, s_exe2mem_freeze, s_mem2wb_bubble}), 32'(e.ctl));
                check("small.busy", 32'(s_busy), 32'(e.busy));
                check("small.mem_err", 32'(s_mem_err), 32'(e.err));
                check("small.lu_stalls", 32'(s_lu), e.lu);
                check("small.br_flushes", 32'(s_br), e.br);
                check("small.mem_waits", 32'(s_mw), e.mw);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        id_src1 = '0; id_src2 = '0; id_uses_src2 = 1'b0; exe_dest = '0;
        exe_mem_r_en = 1'b0; exe_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        step(1'b0, idle());
        step(1'b0, idle());
        step(1'b1, idle());

        // Load-use: one bubble, then the load has moved on.
        s = idle(); s.mr_en = 1; s.dest = 5; s.src1 = 5;
        step(1'b1, s);
        step(1'b1, idle());
        // Load-use through src2 only when the instruction reads it.
        s = idle(); s.mr_en = 1; s.dest = 7; s.src2 = 7; s.uses2 = 1;
        step(1'b1, s);
        s.uses2 = 0;
        step(1'b1, s);
        // A load to r0 never stalls.
        s = idle(); s.mr_en = 1; s.dest = 0; s.src1 = 0;
        step(1'b1, s);

        // Branch flush wins over load-use.
        s = idle(); s.mr_en = 1; s.dest = 5; s.src1 = 5; s.br = 1;
        step(1'b1, s);
        step(1'b1, idle());

        // Memory wait, ready in the 4th cycle; then again with a taken branch throughout.
        for (int pass = 0; pass < 2; pass++) begin
            s = idle(); s.req = 1; s.br = (pass == 1);
            for (int c = 0; c < 3; c++) step(1'b1, s);
            s.rdy = 1;
            step(1'b1, s);
            step(1'b1, idle());
        end
        // Ready in the first cycle: no stall.
        s = idle(); s.req = 1; s.rdy = 1;
        step(1'b1, s);
        step(1'b1, idle());

        // Small instance times out after 4 stall cycles and re-requests; ready then releases both.
        s = idle(); s.req = 1;
        for (int c = 0; c < 6; c++) step(1'b1, s);
        s.rdy = 1;
        step(1'b1, s);
        step(1'b1, idle());
        step(1'b1, idle());

        // Reset asserted mid-wait with idle inputs.
        s = idle(); s.req = 1;
        step(1'b1, s);
        step(1'b1, s);
        step(1'b0, idle());
        step(1'b0, idle());
        step(1'b1, idle());

        // Five load-use bubbles saturate the 2-bit counter at 3.
        s = idle(); s.mr_en = 1; s.dest = 9; s.src1 = 9;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, s);
            step(1'b1, idle());
        end

        // Long stuck access: default instance times out after 255 stall cycles.
        s = idle(); s.req = 1;
        for (int c = 0; c < 258; c++) step(1'b1, s);
        s.rdy = 1;
        step(1'b1, s);
        step(1'b1, idle());

        // Randomized traffic with a small register range to make hazards frequent.
        for (int c = 0; c < 1500; c++) begin
            s.src1  = 5'($urandom_range(0, 3));
            s.src2  = 5'($urandom_range(0, 3));
            s.uses2 = 1'($urandom_range(0, 1));
            s.dest  = 5'($urandom_range(0, 3));
            s.mr_en = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 7) == 0);
            s.req   = ($urandom_range(0, 2) == 0);
            s.rdy   = ($urandom_range(0, 3) == 0);
            step(1'b1, s);
        end
        step(1'b1, idle());

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard drained", 32'(q_big.size() + q_small.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
